modport_apb_slave: RTL and testbench
====================================

MODPORT_APB_SLAVE -- requirements
Module: modport_apb_slave

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, address bus width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data bus width.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 256, number of DATA_WIDTH-bit storage words.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port PCLK, input, 1 bit: clock; all state changes on its rising edge.
REQ-006 The block SHALL have port PRESETn, input, 1 bit: asynchronous reset, active-high (asserted when 1).
REQ-007 The block SHALL have port PSELx, input, 1 bit: slave select.
REQ-008 The block SHALL have port PENABLE, input, 1 bit: access-phase strobe.
REQ-009 The block SHALL have port PWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-010 The block SHALL have port PADDR, input, ADDR_WIDTH bits: word address.
REQ-011 The block SHALL have port PWDATA, input, DATA_WIDTH bits: write data.
REQ-012 The block SHALL have port PRDATA, output, DATA_WIDTH bits: read data, registered.
REQ-013 The block SHALL have port PREADY, output, 1 bit: transfer-complete, registered.
REQ-014 The block SHALL have port PSLVERR, output, 1 bit: transfer error, registered; valid only while PREADY=1.

Function
REQ-015 The FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-016 From IDLE, the FSM SHALL go to SETUP when PSELx=1 and PENABLE=0; otherwise it SHALL stay in IDLE, so PENABLE=1 seen in IDLE is ignored.
REQ-017 From SETUP, the FSM SHALL go to ACCESS when PSELx=1 and PENABLE=1; it SHALL go to IDLE when PSELx=0; it SHALL stay in SETUP when PSELx=1 and PENABLE=0.
REQ-018 From ACCESS, the FSM SHALL go to SETUP when PSELx=1 and PENABLE=0, giving back-to-back transfers; otherwise it SHALL go to IDLE.
REQ-019 Zero wait states: on the edge entering ACCESS, PREADY SHALL be set to 1; on the edge leaving ACCESS, PREADY SHALL clear to 0.
REQ-020 The memory index SHALL be the full PADDR value.
REQ-021 A transfer SHALL be in error when PADDR >= MEM_DEPTH, evaluated on the edge entering ACCESS.
REQ-022 On the edge entering ACCESS, PSLVERR SHALL be loaded with the error flag; on the edge leaving ACCESS, PSLVERR SHALL clear to 0.
REQ-023 Write: on the edge entering ACCESS with PWRITE=1 and no error, mem[PADDR] SHALL be loaded with PWDATA.
REQ-024 On an erroring write, memory SHALL remain unchanged.
REQ-025 Read: on the edge entering ACCESS with PWRITE=0, PRDATA SHALL be loaded with mem[PADDR], or with 0 on error.
REQ-026 PRDATA SHALL be held until the next read load.
REQ-027 During a write transfer, PRDATA SHALL be unchanged.
REQ-028 A read of a word written in the immediately preceding transfer SHALL return the new data.
REQ-029 If PADDR, PWRITE or PWDATA change between SETUP and ACCESS, the values present on the edge entering ACCESS SHALL be used.
REQ-030 Address bits above what MEM_DEPTH needs SHALL take part in the error check only, with no aliasing.

Reset
REQ-031 While PRESETn=1, asynchronously: the FSM SHALL be IDLE, PREADY=0, PSLVERR=0, PRDATA=0, and all MEM_DEPTH words SHALL be 0.
REQ-032 A reset asserted mid-transfer SHALL abort that transfer.
REQ-033 If the aborted transfer is a write whose ACCESS-entry edge has not occurred, no memory write SHALL take place.
REQ-034 After reset release, the first rising edge SHALL evaluate the IDLE transitions.

Verification
REQ-035 Scenario: reset pulse, then idle bus -> PRDATA=0x00000000, PREADY=0, PSLVERR=0; a read of addr 0x05 returns 0x00000000.
REQ-036 Scenario: write 0xDEADBEEF to PADDR 0x10 (SETUP, then ACCESS), then read 0x10 -> PREADY=1 for exactly one cycle per transfer, PSLVERR=0, PRDATA=0xDEADBEEF.
REQ-037 Scenario: write 0x12345678 to PADDR 0x100 (=MEM_DEPTH) -> PSLVERR=1 with PREADY=1; a following read of 0x100 returns PRDATA=0 and PSLVERR=1; a read of 0x00 returns 0.
REQ-038 Scenario: back-to-back writes 0xA5A5A5A5 to 0x01 and 0x5A5A5A5A to 0xFF with PSELx held high -> ACCESS to SETUP with no IDLE between; readback returns both values.
REQ-039 Scenario: assert PRESETn during the SETUP of a write of 0xCAFEF00D to 0x20 -> outputs 0 immediately; a read of 0x20 after release returns 0.
REQ-040 Scenario: PENABLE=1 with PSELx=1 from IDLE (no SETUP) -> no transfer, PREADY stays 0, memory unchanged.

Source files
------------

// File: rtl/modport_apb_slave.sv
// APB slave with a zero-wait-state register-file backing store.
//
// Handshake: a transfer is one SETUP cycle (PSELx=1, PENABLE=0) followed by
// one ACCESS cycle (PSELx=1, PENABLE=1). The slave always completes in that
// ACCESS cycle: PREADY is a registered pulse that is high for exactly the
// ACCESS cycle, and PSLVERR is valid only while PREADY is high. Address,
// direction and write data are taken on the edge that enters ACCESS.
module modport_apb_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [1:0]            state_dbg
);

    // Bus protocol states.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    // Index width; a one-word memory still needs a one-bit index.
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // Depth widened by one bit so the range check never truncates.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  enter_access;
    logic                  addr_err;
    logic [IDX_W-1:0]      idx;

    // Full address is compared, so upper bits can only raise an error and
    // never alias onto a valid word.
    assign addr_err     = ({1'b0, PADDR} >= DEPTH_EXT);
    assign idx          = PADDR[IDX_W-1:0];
    assign enter_access = (state == SETUP) && PSELx && PENABLE;
    assign state_dbg    = state;

    // Next-state decode; PENABLE seen while IDLE never starts a transfer.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (PSELx && !PENABLE) state_nxt = SETUP;
                else                   state_nxt = IDLE;
            end
            SETUP: begin
                if (!PSELx)       state_nxt = IDLE;
                else if (PENABLE) state_nxt = ACCESS;
                else              state_nxt = SETUP;
            end
            ACCESS: begin
                if (PSELx && !PENABLE) state_nxt = SETUP;
                else                   state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Completion and error flags: high only for the ACCESS cycle.
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
        end else begin
            PREADY  <= enter_access;
            PSLVERR <= enter_access && addr_err;
        end
    end

    // Storage array; an out-of-range write leaves every word untouched.
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (enter_access && PWRITE && !addr_err) begin
            mem[idx] <= PWDATA;
        end
    end

    // Read data is loaded only by reads and held through writes and idle.
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            PRDATA <= '0;
        end else if (enter_access && !PWRITE) begin
            PRDATA <= addr_err ? '0 : mem[idx];
        end
    end

endmodule

// File: tb/tb_modport_apb_slave.sv
// Directed bench for modport_apb_slave: inputs change 1ns after the rising
// edge, outputs are checked 1ns after the edge that should have updated them.
module tb_modport_apb_slave;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    logic        PCLK;
    logic        PRESETn;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [1:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    modport_apb_slave #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MEM_DEPTH (256)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PSELx    (PSELx),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .state_dbg(state_dbg)
    );

    // Clock.
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Drive the SETUP phase and take the edge into SETUP.
    task automatic setup_phase(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        PSELx   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
        tick();
    endtask

    // Drive the ACCESS phase (possibly with changed controls) and take the
    // edge into ACCESS.
    task automatic access_phase(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        PENABLE = 1'b1;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
        tick();
    endtask

    // Release the bus and take the edge that leaves ACCESS.
    task automatic bus_idle();
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        tick();
    endtask

    // Complete read; checks the ACCESS-cycle outputs and the cleanup edge.
    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic exp_err);
        setup_phase(1'b0, addr, 32'h0);
        access_phase(1'b0, addr, 32'h0);
        chk({tag, "_ready"}, 32'(PREADY), 32'd1);
        chk({tag, "_err"}, 32'(PSLVERR), 32'(exp_err));
        chk({tag, "_data"}, PRDATA, exp_data);
        bus_idle();
        chk({tag, "_ready_clr"}, 32'(PREADY), 32'd0);
        chk({tag, "_err_clr"}, 32'(PSLVERR), 32'd0);
    endtask

    // Complete write; checks the ACCESS-cycle flags and that PRDATA holds.
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic exp_err, input logic [31:0] hold_rdata);
        setup_phase(1'b1, addr, data);
        access_phase(1'b1, addr, data);
        chk({tag, "_ready"}, 32'(PREADY), 32'd1);
        chk({tag, "_err"}, 32'(PSLVERR), 32'(exp_err));
        chk({tag, "_rdata_hold"}, PRDATA, hold_rdata);
        bus_idle();
        chk({tag, "_ready_clr"}, 32'(PREADY), 32'd0);
        chk({tag, "_err_clr"}, 32'(PSLVERR), 32'd0);
    endtask

    initial begin
        // Reset pulse with an idle bus.
        PRESETn = 1'b1;
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        repeat (3) tick();
        PRESETn = 1'b0;
        tick();
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pready", 32'(PREADY), 32'd0);
        chk("rst_pslverr", 32'(PSLVERR), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
        do_read("rd05_after_rst", 32'h05, 32'h0, 1'b0);

        // Plain write then readback; state walks IDLE -> SETUP -> ACCESS.
        setup_phase(1'b1, 32'h10, 32'hDEADBEEF);
        chk("wr10_state_setup", 32'(state_dbg), 32'(S_SETUP));
        chk("wr10_setup_ready", 32'(PREADY), 32'd0);
        access_phase(1'b1, 32'h10, 32'hDEADBEEF);
        chk("wr10_state_access", 32'(state_dbg), 32'(S_ACCESS));
        chk("wr10_ready", 32'(PREADY), 32'd1);
        chk("wr10_err", 32'(PSLVERR), 32'd0);
        bus_idle();
        chk("wr10_ready_clr", 32'(PREADY), 32'd0);
        chk("wr10_state_idle", 32'(state_dbg), 32'(S_IDLE));
        do_read("rd10", 32'h10, 32'hDEADBEEF, 1'b0);

        // Out-of-range write and read; PRDATA must hold through the write.
        do_write("wr100", 32'h100, 32'h12345678, 1'b1, 32'hDEADBEEF);
        do_read("rd100", 32'h100, 32'h0, 1'b1);
        do_read("rd00", 32'h00, 32'h0, 1'b0);

        // Upper address bits must not alias onto low words.
        do_write("wr105", 32'h105, 32'h77777777, 1'b1, 32'h0);
        do_write("wr80000005", 32'h8000_0005, 32'h66666666, 1'b1, 32'h0);
        do_read("rd05_no_alias", 32'h05, 32'h0, 1'b0);

        // Last valid word.
        do_write("wrff_edge", 32'hFF, 32'h0BADF00D, 1'b0, 32'h0);
        do_read("rdff_edge", 32'hFF, 32'h0BADF00D, 1'b0);

        // Back-to-back writes with PSELx held high.
        setup_phase(1'b1, 32'h01, 32'hA5A5A5A5);
        access_phase(1'b1, 32'h01, 32'hA5A5A5A5);
        chk("b2b1_ready", 32'(PREADY), 32'd1);
        setup_phase(1'b1, 32'hFF, 32'h5A5A5A5A);
        chk("b2b_state_setup", 32'(state_dbg), 32'(S_SETUP));
        chk("b2b_ready_gap", 32'(PREADY), 32'd0);
        access_phase(1'b1, 32'hFF, 32'h5A5A5A5A);
        chk("b2b2_ready", 32'(PREADY), 32'd1);
        chk("b2b2_err", 32'(PSLVERR), 32'd0);
        bus_idle();
        do_read("rd01", 32'h01, 32'hA5A5A5A5, 1'b0);
        do_read("rdff", 32'hFF, 32'h5A5A5A5A, 1'b0);

        // Controls changed between SETUP and ACCESS: ACCESS-edge values win.
        setup_phase(1'b1, 32'h40, 32'h11112222);
        access_phase(1'b1, 32'h41, 32'h33334444);
        bus_idle();
        do_read("rd41_late", 32'h41, 32'h33334444, 1'b0);
        do_read("rd40_late", 32'h40, 32'h0, 1'b0);

        // PENABLE=1 from IDLE without SETUP is ignored.
        PSELx   = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = 32'h30;
        PWDATA  = 32'h11111111;
        tick();
        chk("noset_state1", 32'(state_dbg), 32'(S_IDLE));
        chk("noset_ready1", 32'(PREADY), 32'd0);
        tick();
        chk("noset_state2", 32'(state_dbg), 32'(S_IDLE));
        chk("noset_ready2", 32'(PREADY), 32'd0);
        bus_idle();
        do_read("rd30_noset", 32'h30, 32'h0, 1'b0);

        // Load nonzero PRDATA, then reset in the SETUP of a write.
        do_read("rd01_pre_rst", 32'h01, 32'hA5A5A5A5, 1'b0);
        setup_phase(1'b1, 32'h20, 32'hCAFEF00D);
        PENABLE = 1'b1;
        PRESETn = 1'b1;
        #1;
        chk("midrst_prdata", PRDATA, 32'h0);
        chk("midrst_pready", 32'(PREADY), 32'd0);
        chk("midrst_pslverr", 32'(PSLVERR), 32'd0);
        chk("midrst_state", 32'(state_dbg), 32'(S_IDLE));
        tick();
        PRESETn = 1'b0;
        bus_idle();
        chk("postrst_state", 32'(state_dbg), 32'(S_IDLE));
        do_read("rd20_post_rst", 32'h20, 32'h0, 1'b0);
        do_read("rd01_post_rst", 32'h01, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
